// File: rtl/reg_dump_display.sv
// rtl/reg_dump_display.sv - sequential register-file text dump (signed decimal / hex) for the VGA text buffer
// Optional row label "xNN=" ahead of each field: define REG_DUMP_DISPLAY_LABEL_EN.
module reg_dump_display #(
    parameter int          NUM_REGS   = 33,
    parameter int          DATA_W     = 32,
    parameter int          DEC_DIGITS = 10,
    parameter int          COLS       = 80,
    parameter int          COL_OFFSET = 0,
    parameter int          ADDR_W     = 13,
    parameter logic [23:0] COLOR      = 24'hFFFFFF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
    input  logic                       enable,
    input  logic                       hex_mode,
    output logic                       ascii_write_en,
    output logic [ADDR_W-1:0]          ascii_write_address,
    output logic [31:0]                ascii_input,
    output logic                       busy,
    output logic                       frame_done
);

`ifdef REG_DUMP_DISPLAY_LABEL_EN
    localparam int LBL = 4;
`else
    localparam int LBL = 0;
`endif
    localparam int LAST_COL   = DEC_DIGITS + LBL;
    localparam int HEX_DIGITS = DATA_W / 4;
    localparam int BCD_W      = 4 * DEC_DIGITS;
    localparam int ROW_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int COL_W      = $clog2(LAST_COL + 1);
    localparam int CNT_W      = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, LOAD, CONV, EMIT} state_t;

    state_t            state;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [CNT_W-1:0]  cnt;
    logic              mode_q;
    logic              neg;
    logic [DATA_W-1:0] sh;
    logic [BCD_W-1:0]  bcd;

    logic [DATA_W-1:0] cur_val;
    logic              eff_mode;
    logic [BCD_W-1:0]  bcd_adj;
    logic [7:0]        ch;
    logic [3:0]        nib;
    logic [31:0]       addr_full;
    int                vcol;

    assign cur_val   = regs_flat[int'(row)*DATA_W +: DATA_W];
    // The mode is sampled at the row-0 LOAD; every other row uses the frame's latched mode.
    assign eff_mode  = (row == '0) ? hex_mode : mode_q;
    assign addr_full = 32'(int'(row) * COLS + COL_OFFSET + int'(col));

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DEC_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Digits are always taken from the top of sh/bcd; EMIT shifts them up a nibble per column.
    always_comb begin
        ch   = 8'h20;
        nib  = sh[DATA_W-1 -: 4];
        vcol = int'(col) - LBL;
`ifdef REG_DUMP_DISPLAY_LABEL_EN
        if (col == COL_W'(0))      ch = 8'h78;
        else if (col == COL_W'(1)) ch = 8'h30 + 8'(int'(row) / 10);
        else if (col == COL_W'(2)) ch = 8'h30 + 8'(int'(row) % 10);
        else if (col == COL_W'(3)) ch = 8'h3D;
        else
`endif
        if (vcol == 0)
            ch = mode_q ? 8'h78 : (neg ? 8'h2D : 8'h2B);
        else if (!mode_q)
            ch = 8'h30 + {4'h0, bcd[BCD_W-1 -: 4]};
        else if (vcol <= HEX_DIGITS)
            ch = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            row                 <= '0;
            col                 <= '0;
            cnt                 <= '0;
            mode_q              <= 1'b0;
            neg                 <= 1'b0;
            sh                  <= '0;
            bcd                 <= '0;
            ascii_write_en      <= 1'b0;
            ascii_write_address <= '0;
            ascii_input         <= '0;
            busy                <= 1'b0;
            frame_done          <= 1'b0;
        end else begin
            ascii_write_en <= 1'b0;
            frame_done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (row == '0)
                        mode_q <= hex_mode;
                    neg <= cur_val[DATA_W-1];
                    col <= '0;
                    cnt <= '0;
                    bcd <= '0;
                    if (eff_mode) begin
                        sh    <= cur_val;
                        state <= EMIT;
                    end else begin
                        sh    <= cur_val[DATA_W-1] ? (~cur_val + DATA_W'(1)) : cur_val;
                        state <= CONV;
                    end
                end
                CONV: begin
                    {bcd, sh} <= {bcd_adj[BCD_W-2:0], sh, 1'b0};
                    cnt       <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(DATA_W - 1))
                        state <= EMIT;
                end
                EMIT: begin
                    ascii_write_en      <= 1'b1;
                    ascii_write_address <= addr_full[ADDR_W-1:0];
                    ascii_input         <= {ch, COLOR};
                    if (int'(col) > LBL) begin
                        if (mode_q) sh  <= sh << 4;
                        else        bcd <= bcd << 4;
                    end
                    col <= col + COL_W'(1);
                    if (col == COL_W'(LAST_COL)) begin
                        col <= '0;
                        if (row == ROW_W'(NUM_REGS - 1)) begin
                            frame_done <= 1'b1;
                            row        <= '0;
                        end else begin
                            row <= row + ROW_W'(1);
                        end
                        state <= enable ? LOAD : IDLE;
                        busy  <= enable;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_display.sv
// tb/tb_reg_dump_display.sv - directed table-driven bench for reg_dump_display
module tb_reg_dump_display;

    logic          clk = 1'b0;
    logic          rst;
    logic [1055:0] regs_flat;
    logic          enable;
    logic          hex_mode;
    logic          ascii_write_en;
    logic [12:0]   ascii_write_address;
    logic [31:0]   ascii_input;
    logic          busy;
    logic          frame_done;

    always #5 clk = ~clk;

    reg_dump_display dut (
        .clk                 (clk),
        .rst                 (rst),
        .regs_flat           (regs_flat),
        .enable              (enable),
        .hex_mode            (hex_mode),
        .ascii_write_en      (ascii_write_en),
        .ascii_write_address (ascii_write_address),
        .ascii_input         (ascii_input),
        .busy                (busy),
        .frame_done          (frame_done)
    );

    typedef struct {
        int          row;
        logic [31:0] val;
        logic [87:0] dec_s;
        logic [87:0] hex_s;
    } vec_t;

    vec_t vecs[7];

    int          cyc = 0;
    int          gen = 0;
    logic [7:0]  tbuf [0:8191];
    int          wgen [0:8191];
    int          wcyc [0:8191];
    int          nwrites = 0;
    int          fd_count = 0;
    int          color_err = 0;
    logic [12:0] last_addr = '0;
    logic [12:0] fd_addr = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Text-buffer model: records every character written, tagged with the current test generation.
    always @(negedge clk) begin
        if (ascii_write_en) begin
            tbuf[ascii_write_address] = ascii_input[31:24];
            wgen[ascii_write_address] = gen;
            wcyc[ascii_write_address] = cyc;
            last_addr = ascii_write_address;
            nwrites++;
            if (ascii_input[23:0] !== 24'hFFFFFF) color_err++;
        end
        if (frame_done) begin
            fd_count++;
            fd_addr = last_addr;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_row(input string name, input int row, input logic [87:0] exp);
        logic [87:0] got;
        int a;
        got = '0;
        for (int i = 0; i < 11; i++) begin
            a = row * 80 + i;
            got = {got[79:0], (wgen[a] == gen) ? tbuf[a] : 8'h3F};
        end
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got \"%s\" expected \"%s\"", name, row, got, exp);
        end
    endtask

    task automatic wait_frame(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (frame_done) ok = 1'b1;
        end
    endtask

    task automatic wait_write_addr(input logic [12:0] a, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (ascii_write_en && ascii_write_address == a) ok = 1'b1;
        end
    endtask

    task automatic wait_any_write(input int budget, output bit ok, output logic [12:0] a);
        ok = 1'b0;
        a  = '0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (ascii_write_en) begin
                ok = 1'b1;
                a  = ascii_write_address;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
    endtask

    task automatic restart(input logic hex, output int rel_cyc);
        rst    = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        gen++;
        hex_mode = hex;
        enable   = 1'b1;
        rst      = 1'b0;
        rel_cyc  = cyc;
    endtask

    initial begin
        bit          ok;
        int          rel;
        int          base;
        logic [12:0] a;

        vecs[0] = '{0,  32'h80000000, "-2147483648", "x80000000  "};
        vecs[1] = '{1,  32'h7FFFFFFF, "+2147483647", "x7FFFFFFF  "};
        vecs[2] = '{2,  32'hDEADBEEF, "-0559038737", "xDEADBEEF  "};
        vecs[3] = '{3,  32'h00003039, "+0000012345", "x00003039  "};
        vecs[4] = '{4,  32'h00000000, "+0000000000", "x00000000  "};
        vecs[5] = '{5,  32'hFFFFFFFF, "-0000000001", "xFFFFFFFF  "};
        vecs[6] = '{32, 32'h3B9ACA00, "+1000000000", "x3B9ACA00  "};

        rst       = 1'b1;
        enable    = 1'b0;
        hex_mode  = 1'b0;
        regs_flat = '0;
        for (int i = 0; i < 7; i++) regs_flat[vecs[i].row*32 +: 32] = vecs[i].val;

        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset write_en", 64'(ascii_write_en), 64'd0);
        check("reset frame_done", 64'(frame_done), 64'd0);
        check("reset ascii_input", 64'(ascii_input), 64'd0);
        check("reset address", 64'(ascii_write_address), 64'd0);

        // Decimal frame
        restart(1'b0, rel);
        base = fd_count;
        wait_frame(33 * 44 + 100, ok);
        #1;
        check("dec frame_done seen", 64'(ok), 64'd1);
        check("dec frame_done count", 64'(fd_count - base), 64'd1);
        check("dec frame_done after addr", 64'(fd_addr), 64'd2570);
        check("dec first write latency", 64'(wcyc[0] - rel), 64'd35);
        check("dec row spacing", 64'(wcyc[80] - wcyc[0]), 64'd44);
        check("color bits", 64'(color_err), 64'd0);
        for (int i = 0; i < 7; i++) check_row("dec", vecs[i].row, vecs[i].dec_s);

        // Hex frame; hex_mode drops mid-frame and must only take effect at the next row 0
        restart(1'b1, rel);
        wait_write_addr(13'd80, 200, ok);
        check("hex reach row1", 64'(ok), 64'd1);
        hex_mode = 1'b0;
        wait_frame(33 * 12 + 100, ok);
        #1;
        check("hex frame_done seen", 64'(ok), 64'd1);
        check("hex row spacing 1-2", 64'(wcyc[160] - wcyc[80]), 64'd12);
        check("hex row spacing 31-32", 64'(wcyc[2560] - wcyc[2480]), 64'd12);
        check("hex first write latency", 64'(wcyc[0] - rel), 64'd3);
        for (int i = 0; i < 7; i++) check_row("hex", vecs[i].row, vecs[i].hex_s);
        enable = 1'b0;
        wait_idle(200, ok);
        #1;
        check("hex->dec idle", 64'(ok), 64'd1);
        check_row("relatched mode", 0, vecs[0].dec_s);

        // Enable dropped during row 3 EMIT
        restart(1'b0, rel);
        base = nwrites;
        wait_write_addr(13'd240, 400, ok);
        check("reach row3", 64'(ok), 64'd1);
        enable = 1'b0;
        wait_idle(100, ok);
        #1;
        check("busy falls", 64'(ok), 64'd1);
        check_row("row3 completes", 3, vecs[3].dec_s);
        check("no row4 write", 64'(wgen[320] == gen), 64'd0);
        check("write count", 64'(nwrites - base), 64'd44);
        repeat (20) @(negedge clk);
        check("stays idle busy", 64'(busy), 64'd0);
        check("stays idle writes", 64'(nwrites - base), 64'd44);
        enable = 1'b1;
        wait_any_write(100, ok, a);
        check("resume seen", 64'(ok), 64'd1);
        check("resume address", 64'(a), 64'd320);
        wait_write_addr(13'd330, 50, ok);
        #1;
        check_row("row4 after resume", 4, vecs[4].dec_s);

        // Asynchronous reset during CONV
        restart(1'b0, rel);
        repeat (10) @(posedge clk);
        #2;
        check("conv busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("async rst busy", 64'(busy), 64'd0);
        check("async rst write_en", 64'(ascii_write_en), 64'd0);
        check("async rst ascii_input", 64'(ascii_input), 64'd0);
        @(negedge clk);
        gen++;
        rel = cyc;
        rst = 1'b0;
        wait_any_write(100, ok, a);
        #1;
        check("restart seen", 64'(ok), 64'd1);
        check("restart address", 64'(a), 64'd0);
        check("restart latency", 64'(wcyc[0] - rel), 64'd35);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_dump_display.md
Name: reg_dump_display

Overview:
- Parametrised, sequential successor to the register-file text dump for the VGA debug path.
- Walks NUM_REGS registers of DATA_W bits and converts each row to ASCII with a serial double-dabble converter, one row at a time.
- Writes one character per cycle into the ascii_master_controller write port.
- Supports signed-decimal and hex display modes and continuous frame refresh.

Parameters:
- NUM_REGS, 33, number of registers displayed (one per text row); row NUM_REGS-1 is conventionally pc.
- DATA_W, 32, register width in bits, multiple of 4.
- DEC_DIGITS, 10, decimal digit field width; must satisfy 10^DEC_DIGITS > 2^(DATA_W-1).
- COLS, 80, text-buffer row pitch in characters.
- COL_OFFSET, 0, first column of the field.
- ADDR_W, 13, width of the text-buffer address.
- COLOR, 24'hFFFFFF, colour bits appended to each character.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- regs_flat  in  NUM_REGS*DATA_W  register r occupies bits [r*DATA_W +: DATA_W].
- enable  in  1  run continuous refresh while high.
- hex_mode  in  1  0 = signed decimal, 1 = hex.
- ascii_write_en  out  1  character write strobe.
- ascii_write_address  out  ADDR_W  text-buffer address.
- ascii_input  out  32  {char[7:0], COLOR}.
- busy  out  1  high while any row is in progress.
- frame_done  out  1  one-cycle pulse after the last character of row NUM_REGS-1.

Behaviour:
- Reset: rst is asynchronous and active-high. Asserting it forces IDLE, row=0, col=0 and all outputs to 0 (ascii_input=0), in any state, with no completion of the current row.
- States:
  - IDLE: enable=1 → LOAD.
  - LOAD (1 cycle): snapshot the current row's register into val. At row 0 only, latch hex_mode into mode_q; mode_q holds for the whole frame. Record neg = val[DATA_W-1] and compute mag = neg ? (~val+1) : val, unsigned DATA_W bits. For val = -2^(DATA_W-1), mag = 2^(DATA_W-1), which is legal. Next state: decimal → CONV; hex → EMIT.
  - CONV: DATA_W cycles of double dabble. Each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, mag} left 1. Next state → EMIT.
  - EMIT: DEC_DIGITS+1 cycles, col = 0..DEC_DIGITS. ascii_write_en=1 and ascii_write_address = row*COLS + COL_OFFSET + col, truncated to ADDR_W.
- EMIT characters, decimal mode:
  - col 0 is '-' (8'h2D) if neg, else '+' (8'h2B).
  - cols 1..DEC_DIGITS are the BCD digits most-significant first, as 8'h30+d, with leading zeros shown.
- EMIT characters, hex mode:
  - col 0 is 'x' (8'h78).
  - cols 1..DATA_W/4 are the raw (unsigned) nibbles MSB first: 0-9 → 8'h30+n, A-F → 8'h41+n-10.
  - Remaining cols are ' ' (8'h20).
- After the last col of a row:
  - If row < NUM_REGS-1: row++ and → LOAD.
  - Else: pulse frame_done, row=0, and → LOAD if enable, otherwise → IDLE.
- enable deasserted mid-row: the current row completes, then → IDLE with row held. Reassertion resumes at that row. mode_q is relatched only when a row-0 LOAD occurs.
- Register inputs may change at any time; only the LOAD-cycle snapshot is displayed.
- busy = (state != IDLE).
- ascii_write_en is 0 outside EMIT.
- Outputs are registered, so the first write appears the cycle after entering EMIT.
- Row latency: decimal is 1+DATA_W+DEC_DIGITS+1 cycles (44 for defaults); hex is DEC_DIGITS+2 (12).

Optional Feature:
- Macro: REG_DUMP_DISPLAY_LABEL_EN.
- When defined: EMIT is extended by 4 leading cycles writing the label "xNN=" (row index as two decimal digits, leading zero). The value field shifts right by 4 columns. Row latency grows by 4, and the total field width becomes DEC_DIGITS+5.
- When undefined: no label; the field starts at COL_OFFSET exactly as described above.

Test Plan:
- Reset with regs all 0, enable=1, decimal → row 0 writes "+0000000000" to addresses 0..10, then row 1 starts at address 80; frame_done pulses once after row 32's col 10 (address 2570).
- Reg 5 = 32'hFFFFFFFF, decimal → row 5 writes "-0000000001" at addresses 400..410; ascii_input[23:0] = 24'hFFFFFF.
- Reg 0 = 32'h80000000, decimal → "-2147483648"; reg 1 = 32'h7FFFFFFF → "+2147483647".
- hex_mode=1 with reg 2 = 32'hDEADBEEF → row 2 writes "xDEADBEEF  " at addresses 160..170 with 12-cycle row spacing; toggling hex_mode mid-frame does not change the mode until the next row-0 LOAD.
- Drop enable during row 3 EMIT → row 3 completes, busy falls, no row-4 writes; re-raise enable → resumes at row 4.
- Assert rst mid-CONV → ascii_write_en=0 and busy=0 on the same edge (asynchronously); after release with enable=1, restart at row 0, address 0.
